// File: rtl/nnrv_mem_arb.sv
// Single-port RAM arbiter for the nnrv core: data accesses win by default, and a
// burst counter bounds how long fetch can be starved. Read returns are steered by a one-entry tag.
module nnrv_mem_arb #(
  parameter int DATA_WIDTH   = 64,
  parameter int MASK_WIDTH   = DATA_WIDTH >> 3,
  parameter int XLEN         = 64,
  parameter int MAX_DM_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [XLEN-1:0]       i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [XLEN-1:0]       i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  input  logic [MASK_WIDTH-1:0] i_dm_mask,
  output logic                  o_dm_gnt,
  output logic                  o_dm_rvalid,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic [XLEN-1:0]       o_ram_addr,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [MASK_WIDTH-1:0] o_ram_mask,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data
);

  typedef enum logic [1:0] {
    RTAG_NONE = 2'd0,
    RTAG_IF   = 2'd1,
    RTAG_DM   = 2'd2
  } rtag_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  logic [3:0] burst_cnt_q, burst_cnt_d;
  rtag_e      rtag_q, rtag_d;
  logic       if_gnt, dm_gnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + 4'd1;
  endfunction

  // Grant stage: data wins unless fetch has waited through a full burst.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (i_rst_n) begin
      if (i_dm_req && (!i_if_req || (burst_cnt_q < BURST_MAX))) begin
        dm_gnt = 1'b1;
      end else if (i_if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (if_gnt || !i_if_req) begin
      burst_cnt_d = 4'd0;
    end else if (dm_gnt) begin
      burst_cnt_d = sat_inc(burst_cnt_q);
    end
  end

  always_comb begin
    rtag_d = RTAG_NONE;
    if (if_gnt) begin
      rtag_d = RTAG_IF;
    end else if (dm_gnt && !i_dm_we) begin
      rtag_d = RTAG_DM;
    end
  end

  always_comb begin
    o_ram_addr  = '0;
    o_ram_rd_en = 1'b0;
    o_ram_wr_en = 1'b0;
    o_ram_mask  = '0;
    o_ram_wdata = '0;
    if (if_gnt) begin
      o_ram_addr  = i_if_addr;
      o_ram_rd_en = 1'b1;
      o_ram_mask  = '1;
    end else if (dm_gnt) begin
      o_ram_addr  = i_dm_addr;
      o_ram_mask  = i_dm_mask;
      o_ram_wdata = i_dm_wdata;
      o_ram_wr_en = i_dm_we;
      o_ram_rd_en = ~i_dm_we;
    end
  end

  // Return stage: tag of the read issued last cycle, cleared on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      burst_cnt_q <= 4'd0;
      rtag_q      <= RTAG_NONE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rtag_q      <= rtag_d;
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_dm_gnt = dm_gnt;

  // A read in flight when reset asserts is dropped rather than returned.
  assign o_if_rvalid = (rtag_q == RTAG_IF) && i_rst_n;
  assign o_dm_rvalid = (rtag_q == RTAG_DM) && i_rst_n;
  assign o_if_rdata  = i_ram_rd_data;
  assign o_dm_rdata  = i_ram_rd_data;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Directed bench for nnrv_mem_arb with a behavioural one-cycle RAM and a
// per-cycle return scoreboard.
module tb_nnrv_mem_arb;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int XL = 64;
  localparam int MB = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [XL-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [XL-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [MW-1:0] dm_mask;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [XL-1:0] ram_addr;
  logic          ram_rd_en, ram_wr_en;
  logic [MW-1:0] ram_mask;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rd_data;

  nnrv_mem_arb #(
    .DATA_WIDTH(DW), .MASK_WIDTH(MW), .XLEN(XL), .MAX_DM_BURST(MB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask), .o_dm_gnt(dm_gnt),
    .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
    .o_ram_addr(ram_addr), .o_ram_rd_en(ram_rd_en), .o_ram_wr_en(ram_wr_en),
    .o_ram_mask(ram_mask), .o_ram_wdata(ram_wdata), .i_ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101)};
  endfunction

  logic [63:0] ram [0:255];
  bit          ram_inited;

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else begin
      if (ram_wr_en)
        for (int b = 0; b < 8; b++)
          if (ram_mask[b]) ram[ram_addr[10:3]][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_rd_en) ram_rd_data <= ram[ram_addr[10:3]];
    end
  end

  typedef struct {
    int          kind;
    logic [63:0] data;
  } ret_t;

  ret_t        sbq[$];
  logic [63:0] shadow [0:255];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic e_if, input logic e_dm);
    ret_t        r, n;
    logic        rl;
    logic [63:0] ea, ew;
    logic [7:0]  em;
    rl = !rst_n;
    #1;
    chk({tag, ".if_gnt"}, 64'(if_gnt), 64'(e_if));
    chk({tag, ".dm_gnt"}, 64'(dm_gnt), 64'(e_dm));
    chk({tag, ".rd_en"}, 64'(ram_rd_en), 64'(e_if | (e_dm & ~dm_we)));
    chk({tag, ".wr_en"}, 64'(ram_wr_en), 64'(e_dm & dm_we));
    ea = e_if ? if_addr : (e_dm ? dm_addr : 64'd0);
    em = e_if ? 8'hFF : (e_dm ? dm_mask : 8'h00);
    ew = e_dm ? dm_wdata : 64'd0;
    chk({tag, ".addr"}, ram_addr, ea);
    chk({tag, ".mask"}, 64'(ram_mask), 64'(em));
    if (!e_if) chk({tag, ".wdata"}, ram_wdata, ew);
    if (sbq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      r.kind = 0;
      r.data = '0;
    end else begin
      r = sbq.pop_front();
    end
    if (rl) r.kind = 0;
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(r.kind == 1));
    chk({tag, ".dm_rvalid"}, 64'(dm_rvalid), 64'(r.kind == 2));
    if (r.kind == 1) chk({tag, ".if_rdata"}, if_rdata, r.data);
    if (r.kind == 2) chk({tag, ".dm_rdata"}, dm_rdata, r.data);
    n.kind = 0;
    n.data = '0;
    if (e_if) begin
      n.kind = 1;
      n.data = shadow[if_addr[10:3]];
    end else if (e_dm && !dm_we) begin
      n.kind = 2;
      n.data = shadow[dm_addr[10:3]];
    end
    sbq.push_back(n);
    if (e_dm && dm_we)
      for (int b = 0; b < 8; b++)
        if (dm_mask[b]) shadow[dm_addr[10:3]][8*b +: 8] = dm_wdata[8*b +: 8];
    @(negedge clk);
  endtask

  task automatic chk_burst(input string tag, input int exp);
    chk(tag, 64'(dut.burst_cnt_q), 64'(exp));
  endtask

  initial begin
    ret_t z;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    z.kind = 0;
    z.data = '0;
    sbq.push_back(z);

    // Reset with both requesters asserted: everything forced quiet.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 64'h8;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100; dm_wdata = '0; dm_mask = 8'hFF;
    cyc("rst0", 1'b0, 1'b0);
    cyc("rst1", 1'b0, 1'b0);
    chk_burst("rst.burst", 0);
    rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    cyc("idle0", 1'b0, 1'b0);

    // Fetch only, pipelined reads.
    if_req = 1'b1; if_addr = 64'h0;  cyc("if0", 1'b1, 1'b0);
    if_addr = 64'h8;                 cyc("if1", 1'b1, 1'b0);
    if_addr = 64'h10;                cyc("if2", 1'b1, 1'b0);
    if_req = 1'b0;                   cyc("if_drain", 1'b0, 1'b0);

    // Masked write, then read back.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h100;
    dm_wdata = 64'h0000_0000_DEAD_BEEF; dm_mask = 8'h0F;
    cyc("wr", 1'b0, 1'b1);
    dm_we = 1'b0; dm_mask = 8'hFF;
    cyc("rd", 1'b0, 1'b1);
    dm_req = 1'b0;
    cyc("rd_drain", 1'b0, 1'b0);

    // Fetch grant followed by data read grant.
    if_req = 1'b1; if_addr = 64'h20;
    cyc("mix_if", 1'b1, 1'b0);
    if_req = 1'b0; dm_req = 1'b1; dm_addr = 64'h28;
    cyc("mix_dm", 1'b0, 1'b1);
    dm_req = 1'b0;
    cyc("mix_drain", 1'b0, 1'b0);

    // Contention: DM x4 then IF, repeating.
    if_req = 1'b1; if_addr = 64'h50; dm_req = 1'b1; dm_addr = 64'h48;
    for (int k = 0; k < 10; k++) begin
      cyc($sformatf("burst%0d", k), (k % 5) == 4, (k % 5) != 4);
      chk_burst($sformatf("burst%0d.cnt", k), ((k % 5) == 4) ? 0 : (k % 5) + 1);
    end

    // Fetch request drops for one cycle at burst_cnt 3.
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("drop_pre%0d", k), 1'b0, 1'b1);
      chk_burst($sformatf("drop_pre%0d.cnt", k), k + 1);
    end
    if_req = 1'b0;
    cyc("drop", 1'b0, 1'b1);
    chk_burst("drop.cnt", 0);
    if_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("drop_post%0d", k), k == 4, k != 4);
      chk_burst($sformatf("drop_post%0d.cnt", k), (k == 4) ? 0 : k + 1);
    end
    if_req = 1'b0; dm_req = 1'b0;
    cyc("drop_drain", 1'b0, 1'b0);

    // Reset in the cycle after a fetch grant drops the return.
    if_req = 1'b1; if_addr = 64'h40;
    cyc("rstf_if", 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc("rstf_rst", 1'b0, 1'b0);
    chk_burst("rstf.cnt", 0);
    rst_n = 1'b1; if_req = 1'b0;
    cyc("rstf_after", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
